// File: rtl/nbit_count_up_down_mod.sv
// Parametrised up/down counter with a programmable modulus (limit+1), variable step,
// wrap or saturate at the bounds, synchronous clear/load, and one-cycle registered
// overflow/underflow pulses. The at_max and at_zero compare flags are combinational.
module nbit_count_up_down_mod #(
   parameter int unsigned CNT_WIDTH  = 8,
   parameter int unsigned STEP_WIDTH = 4,
   parameter int unsigned RESET_VAL  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  load,
   input  logic [CNT_WIDTH-1:0]  load_val,
   input  logic                  enable,
   input  logic                  count_up_down,
   input  logic [STEP_WIDTH-1:0] step,
   input  logic [CNT_WIDTH-1:0]  limit,
   input  logic                  sat_mode,
   output logic [CNT_WIDTH-1:0]  counter,
   output logic                  ovf,
   output logic                  unf,
   output logic                  at_max,
   output logic                  at_zero
);

   localparam int unsigned XW = CNT_WIDTH + 1;

   logic [CNT_WIDTH-1:0] counter_q, counter_d;
   logic                 ovf_q, ovf_d;
   logic                 unf_q, unf_d;

   logic [CNT_WIDTH-1:0] step_ext;
   logic [CNT_WIDTH-1:0] eff_step;
   logic [CNT_WIDTH-1:0] load_clamped;
   logic [CNT_WIDTH-1:0] up_wrap;
   logic [CNT_WIDTH-1:0] dn_wrap;
   logic [XW-1:0]        cnt_x;
   logic [XW-1:0]        lim_x;
   logic [XW-1:0]        step_x;
   logic [XW-1:0]        up_sum_x;
   logic                 up_over;
   logic                 dn_under;
   logic                 out_of_range;

   // Datapath: effective step, widened sum and the wrap candidates for both directions.
   always_comb begin
      step_ext     = CNT_WIDTH'(step);
      eff_step     = (step_ext > limit) ? limit : step_ext;
      load_clamped = (load_val > limit) ? limit : load_val;
      out_of_range = (counter_q > limit);

      // One extra bit so counter+step never truncates, even with limit = all ones.
      cnt_x    = {1'b0, counter_q};
      lim_x    = {1'b0, limit};
      step_x   = {1'b0, eff_step};
      up_sum_x = cnt_x + step_x;
      up_over  = (up_sum_x > lim_x);
      dn_under = (counter_q < eff_step);

      // The true wrapped results are always <= limit, so they fit CNT_WIDTH bits and the
      // modular CNT_WIDTH-bit arithmetic yields exactly the wide-computed value.
      up_wrap = counter_q + eff_step - limit - CNT_WIDTH'(1);
      dn_wrap = counter_q - eff_step + limit + CNT_WIDTH'(1);
   end

   // Next-state: clear > load > enable > hold; pulses default low so they last one cycle.
   always_comb begin
      counter_d = counter_q;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
      if (clear) begin
         counter_d = '0;
      end else if (load) begin
         counter_d = load_clamped;
      end else if (enable) begin
         if (out_of_range) begin
            // limit was lowered under the current count: pull back into range silently
            counter_d = sat_mode ? limit : '0;
         end else if (eff_step == '0) begin
            counter_d = counter_q;
         end else if (count_up_down) begin
            if (!up_over) begin
               counter_d = up_sum_x[CNT_WIDTH-1:0];
            end else begin
               ovf_d     = 1'b1;
               counter_d = sat_mode ? limit : up_wrap;
            end
         end else begin
            if (!dn_under) begin
               counter_d = counter_q - eff_step;
            end else begin
               unf_d     = 1'b1;
               counter_d = sat_mode ? '0 : dn_wrap;
            end
         end
      end
   end

   // State register with asynchronous active-high reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         counter_q <= CNT_WIDTH'(RESET_VAL);
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         counter_q <= counter_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   assign counter = counter_q;
   assign ovf     = ovf_q;
   assign unf     = unf_q;
   assign at_max  = (counter_q == limit);
   assign at_zero = (counter_q == '0);

endmodule

// File: tb/tb_nbit_count_up_down_mod.sv
// Scoreboard bench for nbit_count_up_down_mod (CNT_WIDTH=4, STEP_WIDTH=3, RESET_VAL=0).
module tb_nbit_count_up_down_mod;

   localparam int unsigned W  = 4;
   localparam int unsigned SW = 3;

   logic          clk;
   logic          reset;
   logic          clear;
   logic          load;
   logic [W-1:0]  load_val;
   logic          enable;
   logic          count_up_down;
   logic [SW-1:0] step;
   logic [W-1:0]  limit;
   logic          sat_mode;
   logic [W-1:0]  counter;
   logic          ovf;
   logic          unf;
   logic          at_max;
   logic          at_zero;

   nbit_count_up_down_mod #(
      .CNT_WIDTH (W),
      .STEP_WIDTH(SW),
      .RESET_VAL (0)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .load         (load),
      .load_val     (load_val),
      .enable       (enable),
      .count_up_down(count_up_down),
      .step         (step),
      .limit        (limit),
      .sat_mode     (sat_mode),
      .counter      (counter),
      .ovf          (ovf),
      .unf          (unf),
      .at_max       (at_max),
      .at_zero      (at_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string      tag;
      logic [W-1:0] cnt;
      logic       ovf;
      logic       unf;
      logic [W-1:0] lim;
   } exp_t;

   exp_t sb_q[$];

   // reference state for the random phase
   int m_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one edge worth of inputs, queue the expectation, compare after the edge.
   task automatic cyc(input string tag, input logic c, input logic l, input logic [W-1:0] lv,
                      input logic en, input logic up, input logic [SW-1:0] st,
                      input logic [W-1:0] lim, input logic sat, input logic [W-1:0] ecnt,
                      input logic eovf, input logic eunf);
      exp_t e;
      clear         = c;
      load          = l;
      load_val      = lv;
      enable        = en;
      count_up_down = up;
      step          = st;
      limit         = lim;
      sat_mode      = sat;
      e.tag = tag;
      e.cnt = ecnt;
      e.ovf = eovf;
      e.unf = eunf;
      e.lim = lim;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check({tag, ".sb_empty"}, 32'(1), 32'(0));
      end else begin
         e = sb_q.pop_front();
         check({e.tag, ".cnt"},     32'(counter), 32'(e.cnt));
         check({e.tag, ".ovf"},     32'(ovf),     32'(e.ovf));
         check({e.tag, ".unf"},     32'(unf),     32'(e.unf));
         check({e.tag, ".at_max"},  32'(at_max),  32'(e.cnt == e.lim));
         check({e.tag, ".at_zero"}, 32'(at_zero), 32'(e.cnt == 0));
      end
   endtask

   // Integer reference model of one edge.
   task automatic model(input int c, input int l, input int lv, input int en, input int up,
                        input int st, input int lim, input int sat,
                        output int o, output int u);
      int e;
      int s;
      o = 0;
      u = 0;
      if (c != 0) begin
         m_cnt = 0;
      end else if (l != 0) begin
         m_cnt = (lv > lim) ? lim : lv;
      end else if (en != 0) begin
         e = (st > lim) ? lim : st;
         if (m_cnt > lim) begin
            m_cnt = (sat != 0) ? lim : 0;
         end else if (e == 0) begin
            m_cnt = m_cnt;
         end else if (up != 0) begin
            s = m_cnt + e;
            if (s <= lim) m_cnt = s;
            else begin
               o = 1;
               m_cnt = (sat != 0) ? lim : s - (lim + 1);
            end
         end else begin
            if (m_cnt >= e) m_cnt = m_cnt - e;
            else begin
               u = 1;
               m_cnt = (sat != 0) ? 0 : m_cnt + (lim + 1) - e;
            end
         end
      end
   endtask

   initial begin
      int o;
      int u;
      logic          r_c, r_l, r_en, r_up, r_sat;
      logic [W-1:0]  r_lv, r_lim;
      logic [SW-1:0] r_st;

      reset = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0; enable = 1'b0;
      count_up_down = 1'b0; step = '0; limit = 4'd15; sat_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.cnt",     32'(counter), 32'(0));
      check("rst.ovf",     32'(ovf),     32'(0));
      check("rst.unf",     32'(unf),     32'(0));
      check("rst.at_zero", 32'(at_zero), 32'(1));
      reset = 1'b0;

      // 1. async reset mid-count
      for (int i = 1; i <= 5; i++) cyc("t1_up", 0, 0, 0, 1, 1, 1, 15, 0, 4'(i), 0, 0);
      reset = 1'b1;
      #2;
      check("t1_async.cnt", 32'(counter), 32'(0));
      check("t1_async.ovf", 32'(ovf),     32'(0));
      check("t1_async.unf", 32'(unf),     32'(0));
      reset = 1'b0;
      #1;
      cyc("t1_release", 0, 0, 0, 1, 1, 1, 15, 0, 1, 0, 0);

      // 2. decade wrap
      cyc("t2_clr", 1, 0, 0, 0, 1, 1, 9, 0, 0, 0, 0);
      for (int i = 1; i <= 12; i++) cyc("t2_dec", 0, 0, 0, 1, 1, 1, 9, 0, 4'(i % 10), i == 10, 0);

      // 3. down wrap, step 3 (load with enable also high: load wins)
      cyc("t3_load", 0, 1, 1, 1, 0, 3, 9, 0, 1, 0, 0);
      cyc("t3_d0", 0, 0, 0, 1, 0, 3, 9, 0, 8, 0, 1);
      cyc("t3_d1", 0, 0, 0, 1, 0, 3, 9, 0, 5, 0, 0);
      cyc("t3_d2", 0, 0, 0, 1, 0, 3, 9, 0, 2, 0, 0);
      cyc("t3_d3", 0, 0, 0, 1, 0, 3, 9, 0, 9, 0, 1);

      // 4. saturate
      cyc("t4_load", 0, 1, 10, 0, 1, 5, 12, 1, 10, 0, 0);
      for (int i = 0; i < 3; i++) cyc("t4_up", 0, 0, 0, 1, 1, 5, 12, 1, 12, 1, 0);
      cyc("t4_load2", 0, 1, 2, 0, 0, 5, 12, 1, 2, 0, 0);
      cyc("t4_dn0", 0, 0, 0, 1, 0, 5, 12, 1, 0, 0, 1);
      cyc("t4_dn1", 0, 0, 0, 1, 0, 5, 12, 1, 0, 0, 1);

      // 5. priority and load clamp
      cyc("t5_clr_ld", 1, 1, 7, 1, 1, 1, 9, 0, 0, 0, 0);
      cyc("t5_ld_clamp", 0, 1, 14, 0, 1, 1, 9, 0, 9, 0, 0);
      cyc("t5_ld_en", 0, 1, 3, 1, 1, 1, 9, 0, 3, 0, 0);
      cyc("t5_hold", 0, 0, 0, 0, 1, 1, 9, 0, 3, 0, 0);
      cyc("t5_ld9", 0, 1, 9, 0, 1, 1, 9, 0, 9, 0, 0);
      cyc("t5_wrap", 0, 0, 0, 1, 1, 1, 9, 0, 0, 1, 0);
      cyc("t5_pulse_off", 0, 0, 0, 0, 1, 1, 9, 0, 0, 0, 0);

      // 6. step/limit edges
      cyc("t6_load", 0, 1, 2, 0, 1, 7, 3, 0, 2, 0, 0);
      cyc("t6_estep", 0, 0, 0, 1, 1, 7, 3, 0, 1, 1, 0);
      cyc("t6_step0", 0, 0, 0, 1, 1, 0, 3, 0, 1, 0, 0);
      cyc("t6_ld12", 0, 1, 12, 0, 1, 1, 15, 0, 12, 0, 0);
      cyc("t6_oor_wrap", 0, 0, 0, 1, 1, 1, 5, 0, 0, 0, 0);
      cyc("t6_ld12b", 0, 1, 12, 0, 1, 1, 15, 1, 12, 0, 0);
      cyc("t6_oor_sat", 0, 0, 0, 1, 1, 1, 5, 1, 5, 0, 0);
      cyc("t6_lim0_oor", 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0);
      cyc("t6_lim0_up", 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0);
      cyc("t6_lim0_dn", 0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0);
      cyc("t6_ld14", 0, 1, 14, 0, 1, 3, 15, 0, 14, 0, 0);
      cyc("t6_full_up", 0, 0, 0, 1, 1, 3, 15, 0, 1, 1, 0);
      cyc("t6_full_dn", 0, 0, 0, 1, 0, 3, 15, 0, 14, 0, 1);

      // random phase against the integer model
      cyc("rnd_clr", 1, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0);
      m_cnt = 0;
      r_lim = 4'd9;
      r_sat = 1'b0;
      for (int i = 0; i < 300; i++) begin
         r_c  = ($urandom_range(0, 24) == 0);
         r_l  = ($urandom_range(0, 7) == 0);
         r_lv = W'($urandom);
         r_en = ($urandom_range(0, 3) != 0);
         r_up = 1'($urandom);
         r_st = SW'($urandom);
         if ($urandom_range(0, 15) == 0) r_lim = W'($urandom);
         if ($urandom_range(0, 31) == 0) r_sat = ~r_sat;
         model(int'(r_c), int'(r_l), int'(r_lv), int'(r_en), int'(r_up), int'(r_st),
               int'(r_lim), int'(r_sat), o, u);
         cyc("rnd", r_c, r_l, r_lv, r_en, r_up, r_st, r_lim, r_sat, W'(m_cnt), o != 0, u != 0);
      end

      check("sb_drained", 32'(sb_q.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/nbit_count_up_down_mod.md
Name: nbit_count_up_down_mod

Overview:
Parametrised up/down counter with a programmable modulus, variable step, wrap or saturate mode, synchronous clear/load, and registered overflow/underflow event pulses. It extends the plain free-running n-bit up/down counter for use as decade/BCD-style dividers, credit counters and timeout counters. Single clock domain; all outputs are registered except the compare flags.

Parameters:
CNT_WIDTH, 8, counter width in bits (>=2)
STEP_WIDTH, 4, width of step input (<= CNT_WIDTH)
RESET_VAL, 0, counter value on reset; must be <= limit in use

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
clear  input  1  synchronous clear to 0, highest functional priority
load  input  1  synchronous load of load_val
load_val  input  CNT_WIDTH  value to load
enable  input  1  count enable
count_up_down  input  1  1 = count up, 0 = count down
step  input  STEP_WIDTH  increment/decrement amount per enabled cycle
limit  input  CNT_WIDTH  inclusive upper bound; modulus = limit+1
sat_mode  input  1  1 = saturate at bounds, 0 = wrap modulo limit+1
counter  output  CNT_WIDTH  registered count
ovf  output  1  registered, one cycle per up-count crossing limit
unf  output  1  registered, one cycle per down-count crossing 0
at_max  output  1  combinational: counter == limit
at_zero  output  1  combinational: counter == 0

Behaviour:
- Reset (async, any time, incl. mid-count): counter=RESET_VAL, ovf=0, unf=0 immediately; first edge after release acts normally.
- Priority per edge: clear > load > enable > hold.
- clear: counter<=0, ovf/unf<=0.
- load: counter<=min(load_val, limit); ovf/unf<=0.
- enable=0: counter holds; ovf/unf<=0 (pulses last exactly one cycle).
- Effective step e = min(step, limit) (zero-extended). step=0 -> counter holds, no pulse.
- Out-of-range: if enable=1 and counter > limit (limit lowered dynamically): counter<=limit (sat) or 0 (wrap); no pulse.
- Up (count_up_down=1): s = counter+e computed in CNT_WIDTH+1 bits. If s <= limit: counter<=s, ovf<=0. Else ovf<=1 and counter<=limit (sat) or s-(limit+1) (wrap).
- Down (count_up_down=0): if counter >= e: counter<=counter-e, unf<=0. Else unf<=1 and counter<=0 (sat) or counter+(limit+1)-e (wrap), computed in CNT_WIDTH+1 bits.
- Saturate: ovf/unf re-assert on every enabled cycle that clamps (sitting at limit and stepping up pulses every cycle).
- limit=0: counter stays 0; an up or down step with step!=0 pulses ovf/unf respectively, since e=0 makes no move... -> decided: with limit=0, e=0, so no pulse and counter holds at 0.
- limit = 2^CNT_WIDTH-1 with wrap behaves as a plain binary counter; no intermediate truncation allowed.
- Latency: one clock from inputs to counter/ovf/unf; at_max/at_zero follow counter and limit combinationally.
- No X on outputs after reset regardless of input state.

Test Plan:
(CNT_WIDTH=4, STEP_WIDTH=3, RESET_VAL=0)
1. Async reset: count to 5, assert reset between edges -> counter=0 with no clock edge, ovf=unf=0; release, enable up step 1 -> 1 on next edge.
2. Decade wrap: limit=9, step=1, up, sat_mode=0, 12 enabled edges from 0 -> 1..9,0,1,2; ovf high only the cycle after the 9->0 edge; at_max high while counter=9.
3. Down wrap step 3: limit=9, load 1, down -> 8 (unf=1), 5, 2, 9 (unf=1); unf low on the other cycles.
4. Saturate: limit=12, step=5, sat_mode=1, load 10, up -> 12 ovf=1, stays 12 with ovf=1 each cycle; then down from load 2 -> 0 unf=1.
5. Priority/clamp: clear+load same edge -> 0; load_val=14 with limit=9 -> 9; load+enable same edge -> loaded value, no count; enable=0 -> hold, pulses 0.
6. Step/limit edges: limit=3, step=7, load 2, up wrap -> 1 (e=3) ovf=1; step=0 -> hold, no pulse; counter=12 then limit set to 5, enable -> 0 (wrap) / 5 (sat), no pulse.
